// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply controller: op encodings, FSM states,
// result latency and the per-op operand signedness rules.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        ACC  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Cycles from the accepting edge to the done pulse.
    localparam int MUL_LATENCY = 3;

    function automatic logic rs1_is_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Execute-stage request/response bundle for mul_ctrl. The master is the core,
// the slave is mul_ctrl; state_o is a debug view of the controller FSM.
interface mul_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    import muldiv_pkg::*;

    // Handshake: a request is taken when start_i=1, flush_i=0 and busy_o=0 at a
    // rising edge; exactly one done_o pulse follows MUL_LATENCY cycles later
    // unless the operation is flushed or reset first. There is no backpressure.
    logic                  start_i;
    logic [1:0]            op_i;
    logic [DATA_WIDTH-1:0] rs1_i;
    logic [DATA_WIDTH-1:0] rs2_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;
    state_e                state_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  busy_o, done_o, result_o, state_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output busy_o, done_o, result_o, state_o
    );

endinterface

// File: rtl/M.sv
// Two-stage unsigned multiplier: half-width partial products are registered on
// every edge and summed combinationally, so P_o is valid one cycle after X/Y.
module M #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic [DATA_WIDTH-1:0]   X_i,
    input  logic [DATA_WIDTH-1:0]   Y_i,
    output logic [2*DATA_WIDTH-1:0] P_o
);
    localparam int H  = DATA_WIDTH / 2;
    localparam int PP = DATA_WIDTH + H;

    logic [PP-1:0] pp_lo_q, pp_lo_d;
    logic [PP-1:0] pp_hi_q, pp_hi_d;

    always_comb begin
        pp_lo_d = {{H{1'b0}}, X_i} * {{DATA_WIDTH{1'b0}}, Y_i[H-1:0]};
        pp_hi_d = {{H{1'b0}}, X_i} * {{DATA_WIDTH{1'b0}}, Y_i[DATA_WIDTH-1:H]};
    end

    always_ff @(posedge clk_i) begin
        pp_lo_q <= pp_lo_d;
        pp_hi_q <= pp_hi_d;
    end

    // The true product is below 2^(2*DATA_WIDTH), so the truncated sum is exact.
    assign P_o = {{H{1'b0}}, pp_lo_q} + {pp_hi_q, {H{1'b0}}};

endmodule

// File: rtl/mul_ctrl.sv
// Sequencing and sign handling around the unsigned multiplier M for RISC-V
// MUL/MULH/MULHSU/MULHU; DATA_WIDTH must be 32 or 64.
module mul_ctrl
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      reset_i,
    mul_ctrl_if.slave bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ONE_D = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]         ONE_P = {{(PW-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ax_q, ax_d;
    logic [DATA_WIDTH-1:0] ay_q, ay_d;
    logic                  neg_q, neg_d;
    op_e                   op_q, op_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    op_e                   op_in;
    logic                  rs1_neg;
    logic                  rs2_neg;
    logic [DATA_WIDTH-1:0] rs1_mag;
    logic [DATA_WIDTH-1:0] rs2_mag;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         prod_signed;

    assign op_in   = op_e'(bus.op_i);
    assign rs1_neg = rs1_is_signed(op_in) & bus.rs1_i[DATA_WIDTH-1];
    assign rs2_neg = rs2_is_signed(op_in) & bus.rs2_i[DATA_WIDTH-1];
    // The most-negative value negates to itself, which is its correct magnitude.
    assign rs1_mag = rs1_neg ? (~bus.rs1_i + ONE_D) : bus.rs1_i;
    assign rs2_mag = rs2_neg ? (~bus.rs2_i + ONE_D) : bus.rs2_i;

    M #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_m (
        .clk_i (clk_i),
        .X_i   (ax_q),
        .Y_i   (ay_q),
        .P_o   (prod)
    );

    assign prod_signed = neg_q ? (~prod + ONE_P) : prod;

    always_comb begin
        state_d  = state_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        neg_d    = neg_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    state_d = MULT;
                    ax_d    = rs1_mag;
                    ay_d    = rs2_mag;
                    neg_d   = rs1_neg ^ rs2_neg;
                    op_d    = op_in;
                end
            end
            MULT: begin
                state_d = bus.flush_i ? IDLE : ACC;
            end
            ACC: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = (op_q == OP_MUL) ? prod_signed[DATA_WIDTH-1:0]
                                                : prod_signed[PW-1:DATA_WIDTH];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            ax_q     <= '0;
            ay_q     <= '0;
            neg_q    <= 1'b0;
            op_q     <= OP_MUL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.done_o   = (state_q == DONE);
    assign bus.result_o = result_q;
    assign bus.state_o  = state_q;

endmodule
